// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared constants and helpers for the digit scan controller
package fnd_pkg;

    localparam int CODE_W = 5;
    localparam int NDIG   = 4;
    localparam int IDX_W  = 2;

    // Code the segment decoder renders as an unlit digit
    localparam logic [CODE_W-1:0] CODE_BLANK = 5'h0F;

    // Message glyph codes understood by the segment decoder
    localparam logic [CODE_W-1:0] CODE_E    = 5'h10;
    localparam logic [CODE_W-1:0] CODE_R    = 5'h11;
    localparam logic [CODE_W-1:0] CODE_RDOT = 5'h12;
    localparam logic [CODE_W-1:0] CODE_T    = 5'h13;
    localparam logic [CODE_W-1:0] CODE_O    = 5'h14;
    localparam logic [CODE_W-1:0] CODE_U    = 5'h15;
    localparam logic [CODE_W-1:0] CODE_H    = 5'h16;
    localparam logic [CODE_W-1:0] CODE_D    = 5'h17;

    // Active-low one-cold common select for a digit index
    function automatic logic [NDIG-1:0] com_sel(input logic [IDX_W-1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler producing one tick every DIV cycles
module tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    // Count 0..DIV-1 and wrap on the tick cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - four-digit multiplexed display scanner with blanking and blink
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter int BLINK_TICKS = 250
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [NDIG*CODE_W-1:0] digits_in,
    input  logic                   blank_lz,
    input  logic [NDIG-1:0]        blink_mask,
    output logic [CODE_W-1:0]      bcd,
    output logic [NDIG-1:0]        fnd_com,
    output logic                   frame_done
);

    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
    localparam logic [NDIG*CODE_W-1:0] ACTIVE_RST = {NDIG{CODE_BLANK}};

    logic                   tick;
    logic [IDX_W-1:0]       idx;
    logic                   phase;
    logic [BW-1:0]          blink_cnt;
    logic [NDIG*CODE_W-1:0] active;
    logic [NDIG*CODE_W-1:0] pending;
    logic                   pend_v;

    logic                   frame_end;
    logic                   blink_wrap;
    logic [IDX_W-1:0]       next_idx;
    logic                   next_phase;
    logic [NDIG*CODE_W-1:0] next_active;
    logic [CODE_W-1:0]      next_code;
    logic                   lz_blank;
    logic [CODE_W-1:0]      next_bcd;

    tick_gen #(
        .DIV(SCAN_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // frame_done is the tick that leaves the last digit slot
    assign frame_end  = tick && (idx == IDX_W'(NDIG - 1));
    assign frame_done = frame_end;
    assign blink_wrap = tick && (blink_cnt == BLINK_LAST);

    // Look ahead to the state after this edge so bcd/fnd_com move together with idx
    // and the first digit of a new frame already shows the newly committed data
    always_comb begin
        next_idx    = tick ? idx + IDX_W'(1) : idx;
        next_phase  = phase ^ blink_wrap;
        next_active = active;
        if (frame_end) begin
            if (load) begin
                next_active = digits_in;
            end else if (pend_v) begin
                next_active = pending;
            end
        end
        next_code = next_active[next_idx*CODE_W +: CODE_W];
        lz_blank  = blank_lz && (next_idx != '0);
        for (int j = 0; j < NDIG; j++) begin
            if ((j >= int'(next_idx)) && (next_active[j*CODE_W +: CODE_W] != '0)) begin
                lz_blank = 1'b0;
            end
        end
        if (lz_blank || (next_phase && blink_mask[next_idx])) begin
            next_bcd = CODE_BLANK;
        end else begin
            next_bcd = next_code;
        end
    end

    // Scan state, double-buffered digit data and registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            phase     <= 1'b0;
            blink_cnt <= '0;
            active    <= ACTIVE_RST;
            pending   <= '0;
            pend_v    <= 1'b0;
            fnd_com   <= com_sel('0);
            bcd       <= CODE_BLANK;
        end else begin
            idx     <= next_idx;
            phase   <= next_phase;
            active  <= next_active;
            fnd_com <= com_sel(next_idx);
            bcd     <= next_bcd;
            if (tick) begin
                blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
            end
            // A load on the frame boundary goes straight to active, so nothing stays pending
            if (frame_end) begin
                pend_v <= 1'b0;
            end else if (load) begin
                pending <= digits_in;
                pend_v  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb/tb_fnd_scan_ctrl.sv - randomized scoreboard bench for the digit scan controller
module tb_fnd_scan_ctrl;

    localparam int SD    = 4;
    localparam int BT    = 2;
    localparam int FRAME = SD * 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [19:0] digits_in = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  blink_mask = '0;
    logic [4:0]  bcd;
    logic [3:0]  fnd_com;
    logic        frame_done;

    fnd_scan_ctrl #(
        .SCAN_DIV   (SD),
        .BLINK_TICKS(BT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .digits_in (digits_in),
        .blank_lz  (blank_lz),
        .blink_mask(blink_mask),
        .bcd       (bcd),
        .fnd_com   (fnd_com),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tgt;
        logic [3:0] com;
        logic [4:0] code;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   gcyc = 0;
    int   errors = 0;
    int   checks = 0;

    // Reference model: time since reset decides slot/digit/phase; data per frame
    logic [19:0] m_active;
    logic [19:0] m_next;
    bit          m_has;
    int          m_c;
    logic        cur_bl = 1'b0;
    logic [3:0]  cur_bm = '0;

    always @(posedge clk) gcyc++;

    // Monitor: compare the DUT outputs against the entry scheduled for this cycle
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].tgt < gcyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL stale_entry tgt=%0d now=%0d", e.tgt, gcyc);
        end
        if (q.size() > 0 && q[0].tgt == gcyc) begin
            e = q.pop_front();
            checks++;
            if (fnd_com !== e.com || bcd !== e.code || frame_done !== e.fd) begin
                errors++;
                $display("FAIL scan cyc=%0d got com=%b bcd=%h fd=%b want com=%b bcd=%h fd=%b",
                         gcyc, fnd_com, bcd, frame_done, e.com, e.code, e.fd);
            end
        end
    end

    task automatic step(input logic r, input logic ld, input logic [19:0] d);
        exp_t e;
        int   slot, i, ph, nsig;
        @(posedge clk);
        #1;
        reset      = r;
        load       = ld;
        digits_in  = d;
        blank_lz   = cur_bl;
        blink_mask = cur_bm;
        e.tgt = gcyc + 1;
        if (r) begin
            m_active = {4{5'h0F}};
            m_has    = 1'b0;
            m_c      = 0;
            e.com    = 4'b1110;
            e.code   = 5'h0F;
            e.fd     = 1'b0;
        end else begin
            if (ld) begin
                m_next = d;
                m_has  = 1'b1;
            end
            if (m_c % FRAME == FRAME - 1) begin
                if (m_has) m_active = m_next;
                m_has = 1'b0;
            end
            m_c++;
            slot = m_c / SD;
            i    = slot % 4;
            ph   = (slot / BT) % 2;
            nsig = 1;
            for (int j = 0; j < 4; j++)
                if (m_active[j*5 +: 5] != 5'h00) nsig = j + 1;
            e.com = 4'b1111;
            e.com[i] = 1'b0;
            if ((cur_bl && i >= nsig) || (ph == 1 && cur_bm[i]))
                e.code = 5'h0F;
            else
                e.code = m_active[i*5 +: 5];
            e.fd = (m_c % FRAME == FRAME - 1);
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, digits_in);
    endtask

    task automatic to_frame_end();
        while (m_c % FRAME != FRAME - 1) step(1'b0, 1'b0, digits_in);
    endtask

    function automatic logic [19:0] rnd_digits();
        logic [19:0] v = '0;
        for (int j = 0; j < 4; j++)
            v[j*5 +: 5] = ($urandom_range(0, 1) == 0) ? 5'h00 : 5'($urandom_range(0, 31));
        return v;
    endfunction

    initial begin
        logic       r, ld;
        logic [19:0] d;
        // Reset then free scanning of the blank power-up data
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        idle(40);
        // Mid-frame load must wait for the frame boundary
        idle(5);
        step(1'b0, 1'b1, {5'h04, 5'h03, 5'h02, 5'h01});
        idle(40);
        // Load exactly on frame_done goes to the very next frame
        to_frame_end();
        step(1'b0, 1'b1, {5'h13, 5'h12, 5'h11, 5'h10});
        idle(20);
        // Two loads in one frame: last one wins
        step(1'b0, 1'b1, {5'h1F, 5'h1E, 5'h1D, 5'h1C});
        step(1'b0, 1'b1, {5'h17, 5'h16, 5'h15, 5'h14});
        idle(36);
        // Leading-zero blanking
        cur_bl = 1'b1;
        step(1'b0, 1'b1, {5'h00, 5'h00, 5'h07, 5'h00});
        idle(40);
        step(1'b0, 1'b1, 20'h0);
        idle(40);
        // Blink on digit 0
        cur_bl = 1'b0;
        cur_bm = 4'b0001;
        step(1'b0, 1'b1, {5'h01, 5'h02, 5'h03, 5'h05});
        idle(80);
        cur_bm = 4'b0000;
        // Load then reset before the boundary: pending data is discarded
        to_frame_end();
        idle(4);
        step(1'b0, 1'b1, {5'h09, 5'h08, 5'h06, 5'h05});
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        idle(40);
        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) cur_bl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) cur_bm = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 399) == 0);
            if (m_c % FRAME == FRAME - 1)
                ld = ($urandom_range(0, 2) == 0);
            else
                ld = ($urandom_range(0, 19) == 0);
            d = rnd_digits();
            step(r, ld, d);
        end
        idle(1);
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d left want 0", q.size());
        end
        checks++;
        if (checks < 3000) begin
            errors++;
            $display("FAIL check_count got %0d want at least 3000", checks);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
